// File: rtl/bypass_pkg.sv
// Shared definitions for the bypass sequencer: channel state encoding and
// default timing constants (in 200 us ticks).
package bypass_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    CLOSE    = 3'd2,
    BYPASSED = 3'd3,
    FB_FAIL  = 3'd4
  } bypass_state_e;

  localparam int DLY_W_DEF     = 8;
  localparam int DLY_TICKS_DEF = 100;
  localparam int FB_TMO_DEF    = 50;

  function automatic logic state_is_active(input bypass_state_e s);
    return (s == CLOSE) || (s == BYPASSED) || (s == FB_FAIL);
  endfunction

endpackage

// File: rtl/bypass_ch.sv
// One bypass channel: fault-persistence delay, latched bypass drive and,
// when BYPASS_FB_CHECK_EN is defined, a contactor-feedback timeout check.
//   state    | meaning
//   IDLE     | no fault, drive off
//   ARM      | fault present, counting persistence ticks
//   CLOSE    | drive on, waiting for contactor feedback
//   BYPASSED | drive on, latched until released by clr
//   FB_FAIL  | drive on, feedback never arrived, fb_fault raised
module bypass_ch
  import bypass_pkg::*;
#(
  parameter int DLY_W     = DLY_W_DEF,
  parameter int DLY_TICKS = DLY_TICKS_DEF,
  parameter int FB_TMO    = FB_TMO_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic tick,
  input  logic call_fault,
  input  logic cmd_bypass,
  input  logic clr,
  input  logic bypass_fb_n,
  output logic bypass_o,
  output logic byp_active,
  output logic fb_fault,
  output logic busy
);

  localparam logic [DLY_W-1:0] ONE     = DLY_W'(1);
  localparam logic [DLY_W-1:0] DLY_LIM = DLY_W'(DLY_TICKS);

  bypass_state_e    state_q;
  logic [DLY_W-1:0] dly_cnt_q;
  logic [DLY_W-1:0] dly_nxt;
  logic             bypass_q;
  logic             active_q;
  logic             busy_q;
  logic             release_ok;

  assign dly_nxt    = dly_cnt_q + ONE;
  assign release_ok = clr & ~call_fault & ~cmd_bypass;

`ifdef BYPASS_FB_CHECK_EN
  localparam logic [DLY_W-1:0] TMO_LIM = DLY_W'(FB_TMO);

  logic [DLY_W-1:0] tmo_cnt_q;
  logic [DLY_W-1:0] tmo_nxt;
  logic             fb_meta_q;
  logic             fb_sync_q;
  logic             fb_fault_q;

  assign tmo_nxt  = tmo_cnt_q + ONE;
  assign fb_fault = fb_fault_q;

  // Synchroniser idles high so reset never looks like a closed contactor.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fb_meta_q <= 1'b1;
      fb_sync_q <= 1'b1;
    end else begin
      fb_meta_q <= bypass_fb_n;
      fb_sync_q <= fb_meta_q;
    end
  end
`else
  logic unused_fb;
  assign unused_fb = ^{bypass_fb_n, DLY_W'(FB_TMO)};
  assign fb_fault  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      dly_cnt_q  <= '0;
      bypass_q   <= 1'b0;
      active_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef BYPASS_FB_CHECK_EN
      tmo_cnt_q  <= '0;
      fb_fault_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_bypass) begin
            state_q   <= CLOSE;
            dly_cnt_q <= '0;
            bypass_q  <= 1'b1;
            active_q  <= 1'b1;
            busy_q    <= 1'b1;
`ifdef BYPASS_FB_CHECK_EN
            tmo_cnt_q <= '0;
`endif
          end else if (call_fault) begin
            state_q   <= ARM;
            dly_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end

        ARM: begin
          if (cmd_bypass) begin
            state_q   <= CLOSE;
            dly_cnt_q <= '0;
            bypass_q  <= 1'b1;
            active_q  <= 1'b1;
`ifdef BYPASS_FB_CHECK_EN
            tmo_cnt_q <= '0;
`endif
          end else if (!call_fault) begin
            // Any gap in the fault restarts the persistence window.
            state_q   <= IDLE;
            dly_cnt_q <= '0;
            busy_q    <= 1'b0;
          end else if (tick) begin
            if (dly_nxt == DLY_LIM) begin
              state_q   <= CLOSE;
              dly_cnt_q <= '0;
              bypass_q  <= 1'b1;
              active_q  <= 1'b1;
`ifdef BYPASS_FB_CHECK_EN
              tmo_cnt_q <= '0;
`endif
            end else if (dly_cnt_q != '1) begin
              dly_cnt_q <= dly_nxt;
            end
          end
        end

        CLOSE: begin
`ifdef BYPASS_FB_CHECK_EN
          if (!fb_sync_q) begin
            state_q <= BYPASSED;
          end else if (tick) begin
            if (tmo_nxt == TMO_LIM) begin
              state_q    <= FB_FAIL;
              fb_fault_q <= 1'b1;
            end else if (tmo_cnt_q != '1) begin
              tmo_cnt_q <= tmo_nxt;
            end
          end
`else
          state_q <= BYPASSED;
`endif
        end

        BYPASSED, FB_FAIL: begin
          if (release_ok) begin
            state_q    <= IDLE;
            bypass_q   <= 1'b0;
            active_q   <= 1'b0;
            busy_q     <= 1'b0;
`ifdef BYPASS_FB_CHECK_EN
            tmo_cnt_q  <= '0;
            fb_fault_q <= 1'b0;
`endif
          end
        end

        default: begin
          state_q   <= IDLE;
          dly_cnt_q <= '0;
          bypass_q  <= 1'b0;
          active_q  <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bypass_o   = bypass_q;
  assign byp_active = active_q;
  assign busy       = busy_q;

endmodule

// File: rtl/bypass_seq.sv
// Multi-channel bypass sequencer: N_CH independent bypass_ch instances.
// Optional contactor-feedback check is enabled by defining BYPASS_FB_CHECK_EN.
module bypass_seq
  import bypass_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DLY_W     = DLY_W_DEF,
  parameter int DLY_TICKS = DLY_TICKS_DEF,
  parameter int FB_TMO    = FB_TMO_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            tick,
  input  logic [N_CH-1:0] call_fault,
  input  logic [N_CH-1:0] cmd_bypass,
  input  logic [N_CH-1:0] clr,
  input  logic [N_CH-1:0] bypass_fb_n,
  output logic [N_CH-1:0] bypass_o,
  output logic [N_CH-1:0] byp_active,
  output logic [N_CH-1:0] fb_fault,
  output logic            busy
);

  logic [N_CH-1:0] ch_busy;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    bypass_ch #(
      .DLY_W     (DLY_W),
      .DLY_TICKS (DLY_TICKS),
      .FB_TMO    (FB_TMO)
    ) u_ch (
      .clk         (clk),
      .rstn        (rstn),
      .tick        (tick),
      .call_fault  (call_fault[g]),
      .cmd_bypass  (cmd_bypass[g]),
      .clr         (clr[g]),
      .bypass_fb_n (bypass_fb_n[g]),
      .bypass_o    (bypass_o[g]),
      .byp_active  (byp_active[g]),
      .fb_fault    (fb_fault[g]),
      .busy        (ch_busy[g])
    );
  end

  // Per-channel busy bits are flops, so the OR stays aligned with bypass_o.
  assign busy = |ch_busy;

endmodule

// File: doc/bypass_seq.md
# bypass_seq

Parametrised, multi-channel bypass sequencer for the power-unit board. It replaces the single fixed 20 ms fault-to-bypass delay with one independent channel per bypass contactor. Each channel has a programmable fault-persistence delay counted in 200 µs ticks, a latched bypass state and an optional contactor-feedback check. It sits between the fault/command outputs of `pwm_up`/`pwm_down` and the `bypass_o` pins.

## Interface
- `N_CH`, default 4: number of independent bypass channels.
- `DLY_W`, default 8: width of the delay and timeout counters.
- `DLY_TICKS`, default 100: ticks of continuous fault before bypass (100 × 200 µs = 20 ms). Range 1..2^DLY_W−1.
- `FB_TMO`, default 50: ticks allowed for contactor feedback after bypass closes. Range 1..2^DLY_W−1.

- `clk` in 1: system clock.
- `rstn` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle pulse every 200 µs (`tri_200us == 1` decode).
- `call_fault` in N_CH: per-channel fault request, level.
- `cmd_bypass` in N_CH: per-channel host bypass command, level.
- `clr` in N_CH: per-channel release request, single-cycle pulse.
- `bypass_fb_n` in N_CH: contactor feedback, active-low, asynchronous.
- `bypass_o` out N_CH: bypass drive, registered.
- `byp_active` out N_CH: channel is in CLOSE, BYPASSED or FB_FAIL.
- `fb_fault` out N_CH: feedback timeout, sticky until release.
- `busy` out 1: OR of all channels not in IDLE.

## Operation
Each channel runs its own FSM with states IDLE, ARM, CLOSE, BYPASSED, FB_FAIL.

- **IDLE**
  - `cmd_bypass` = 1 → CLOSE.
  - `call_fault` = 1 → ARM, with dly_cnt = 0.
- **ARM**
  - `cmd_bypass` = 1 → CLOSE immediately.
  - `call_fault` = 0 → IDLE, and dly_cnt is cleared. The old design held the count instead.
  - Otherwise dly_cnt increments on each `tick`. When the increment would make dly_cnt reach DLY_TICKS → CLOSE.
- **CLOSE**
  - `bypass_o` = 1 and tmo_cnt = 0 on entry.
  - Feedback handling is set by the macro (see Configuration).
- **BYPASSED**
  - `bypass_o` = 1. The state is latched regardless of `call_fault`.
  - `clr` = 1 with `call_fault` = 0 and `cmd_bypass` = 0 → IDLE. Any other `clr` is ignored.
- **FB_FAIL**
  - `bypass_o` = 1 (the drive is kept) and `fb_fault` = 1.
  - Released by `clr` under the same conditions as BYPASSED.
- Precedence in a single cycle: `cmd_bypass` > fault drop > `tick` increment.
  - Example: `call_fault` falls in the same cycle as the final `tick` → IDLE, no bypass.
- Channels are fully independent. There is no shared arbitration.
- Counters saturate. They never wrap.

## Timing
- Reset value of every output is 0. All FSMs go to IDLE and all counters to 0.
- Assertion of `rstn` mid-operation drops `bypass_o` asynchronously.
- `bypass_o` latencies:
  - 1 cycle after `cmd_bypass` is sampled high in IDLE or ARM.
  - 1 cycle after the DLY_TICKS-th qualifying `tick`.
- `byp_active` and `busy` are registered, aligned with `bypass_o`.
- `bypass_fb_n` passes through a 2-flop synchroniser, so the feedback decision lags the pin by 2 cycles.
- `tick` is assumed to be one cycle wide. If it is held high it counts once per cycle.
- `clr` acts in the cycle it is sampled: `bypass_o` falls 1 cycle later.

## Configuration
- `BYPASS_FB_CHECK_EN` defined:
  - In CLOSE, synchronised `bypass_fb_n` = 0 → BYPASSED.
  - Otherwise tmo_cnt increments on each `tick`. Reaching FB_TMO → FB_FAIL.
- `BYPASS_FB_CHECK_EN` undefined:
  - CLOSE → BYPASSED unconditionally on the next cycle.
  - `bypass_fb_n` is unused, the synchroniser and tmo_cnt are removed, and `fb_fault` is tied 0.

## Structure
- Shared package `bypass_pkg`:
  - State encoding (3-bit enum IDLE=0, ARM=1, CLOSE=2, BYPASSED=3, FB_FAIL=4).
  - Default DLY_TICKS/FB_TMO constants.
- Sub-module `bypass_ch` holds one channel's FSM, counters and synchroniser.
- `bypass_seq` instantiates N_CH copies in a generate loop and ORs `busy`.

## Test plan
- N_CH=4, DLY_TICKS=100: hold `call_fault[0]` high → `bypass_o[0]` rises 1 cycle after the 100th tick; other channels stay 0.
- `call_fault[1]` high for 60 ticks, low for 1 cycle, high again → `bypass_o[1]` rises only after 100 further ticks (counter was cleared).
- `cmd_bypass[2]` pulse in IDLE → `bypass_o[2]` = 1 next cycle; `clr[2]` with no fault → `bypass_o[2]` = 0 one cycle later. `clr` with `call_fault[2]` = 1 is ignored.
- With `BYPASS_FB_CHECK_EN`, FB_TMO=50:
  - `bypass_fb_n[3]` stuck high after close → `fb_fault[3]` = 1 at the 50th tick, `bypass_o[3]` stays 1.
  - Feedback low at tick 10 → BYPASSED, `fb_fault` = 0.
- Final tick coincident with `call_fault` falling → no bypass, FSM in IDLE; `rstn` low while BYPASSED → all outputs 0 immediately.
